// File: rtl/avalon_arb_pkg.sv
// Shared types and defaults for the two-master Avalon-MM bus arbiter.
package avalon_arb_pkg;

   localparam int ARB_DEF_ADDR_W = 32;
   localparam int ARB_DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_t;

   // Master index: 0 = CPU bus interface, 1 = debug loader / DMA
   typedef logic arb_id_t;

   localparam arb_id_t ARB_M0 = 1'b0;
   localparam arb_id_t ARB_M1 = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the Avalon bus arbiter.
// Build option AVALON_ARB_ROUND_ROBIN_EN: on contention the master that did
// not win last time is picked; otherwise m0 always wins a contention.
module arb_pick
   import avalon_arb_pkg::*;
(
   input  logic [1:0] i_req,
   input  arb_id_t    i_last_grant,
   output arb_id_t    o_winner
);

`ifdef AVALON_ARB_ROUND_ROBIN_EN
   // Alternate on contention, otherwise take the single requester
   always_comb begin
      if (i_req == 2'b11)
         o_winner = ~i_last_grant;
      else if (i_req[1])
         o_winner = ARB_M1;
      else
         o_winner = ARB_M0;
   end
`else
   // History is not needed for fixed priority
   logic w_unused_last_grant;
   assign w_unused_last_grant = i_last_grant;

   // Fixed priority: m0 wins whenever it requests
   always_comb begin
      if (i_req[0])
         o_winner = ARB_M0;
      else if (i_req[1])
         o_winner = ARB_M1;
      else
         o_winner = ARB_M0;
   end
`endif

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter in front of the unified instruction/data RAM.
// One arbitration cycle per transfer; the grant is held until the slave drops
// waitrequest, and read data returns to the owner one cycle later.
// Build option AVALON_ARB_ROUND_ROBIN_EN selects alternating priority (see arb_pick).
module avalon_bus_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_DEF_ADDR_W,
   parameter int DATA_W = ARB_DEF_DATA_W
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata
);

   logic [1:0] r_rst_sync;
   logic       w_rst_n;
   arb_state_t r_state;
   arb_state_t w_state_next;
   arb_id_t    r_rd_owner;
   arb_id_t    r_last_grant;
   arb_id_t    w_winner;
   logic       r_rd_valid;
   logic [1:0] w_req;
   logic       w_g0;
   logic       w_g1;
   logic       w_acc0;
   logic       w_acc1;

   // Reset asserts immediately, releases after two clean clock edges
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_rst_sync <= 2'b00;
      else
         r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_req  = {m1_read | m1_write, m0_read | m0_write};
   assign w_g0   = w_rst_n && (r_state == ARB_GRANT0);
   assign w_g1   = w_rst_n && (r_state == ARB_GRANT1);
   assign w_acc0 = w_g0 && w_req[0] && !s_waitrequest;
   assign w_acc1 = w_g1 && w_req[1] && !s_waitrequest;

   arb_pick u_pick (
      .i_req        (w_req),
      .i_last_grant (r_last_grant),
      .o_winner     (w_winner)
   );

   // Grant on a request, release on acceptance or on a dropped request
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ARB_IDLE:
            if (|w_req)
               w_state_next = (w_winner == ARB_M1) ? ARB_GRANT1 : ARB_GRANT0;
         ARB_GRANT0:
            if (!w_req[0] || !s_waitrequest)
               w_state_next = ARB_IDLE;
         ARB_GRANT1:
            if (!w_req[1] || !s_waitrequest)
               w_state_next = ARB_IDLE;
         default:
            w_state_next = ARB_IDLE;
      endcase
   end

   // State, read-return tracking and grant history
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state      <= ARB_IDLE;
         r_rd_valid   <= 1'b0;
         r_rd_owner   <= ARB_M0;
         r_last_grant <= ARB_M1;
      end else begin
         r_state    <= w_state_next;
         r_rd_valid <= (w_acc0 && m0_read) || (w_acc1 && m1_read);
         if (w_acc0 && m0_read)
            r_rd_owner <= ARB_M0;
         else if (w_acc1 && m1_read)
            r_rd_owner <= ARB_M1;
         if (w_acc0)
            r_last_grant <= ARB_M0;
         else if (w_acc1)
            r_last_grant <= ARB_M1;
      end
   end

   // Route the granted master to the slave; everyone else is stalled
   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      if (w_g0) begin
         s_address      = m0_address;
         s_read         = m0_read;
         s_write        = m0_write;
         s_writedata    = m0_writedata;
         s_byteenable   = m0_byteenable;
         m0_waitrequest = s_waitrequest;
      end else if (w_g1) begin
         s_address      = m1_address;
         s_read         = m1_read;
         s_write        = m1_write;
         s_writedata    = m1_writedata;
         s_byteenable   = m1_byteenable;
         m1_waitrequest = s_waitrequest;
      end
   end

   // Read data is broadcast; only the owner sees it marked valid
   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = r_rd_valid && (r_rd_owner == ARB_M0);
   assign m1_readdatavalid = r_rd_valid && (r_rd_owner == ARB_M1);

   // Flag master protocol violations in simulation
   always_ff @(posedge clk) begin
      if (w_rst_n) begin
         if (w_g0)
            assert (w_req[0]) else $error("avalon_bus_arbiter: m0 dropped its request while granted");
         if (w_g1)
            assert (w_req[1]) else $error("avalon_bus_arbiter: m1 dropped its request while granted");
         assert (!(m0_read && m0_write)) else $error("avalon_bus_arbiter: m0 read and write together");
         assert (!(m1_read && m1_write)) else $error("avalon_bus_arbiter: m1 read and write together");
      end
   end

endmodule
